inv_cipher: RTL

Iterative AES inverse cipher (FIPS-197 §5.3) that decrypts one 128-bit block per start using a fully expanded key schedule, one inverse round per clock. It is the receive-side counterpart of the encryption core: it consumes the same expanded-key bus layout and produces plaintext with a start/busy/done handshake for the surrounding datapath.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/inv_cipher_if.sv | 12 +
 rtl/inv_cipher_round.sv | 17 +
 rtl/inv_cipher.sv | 65 ++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, FSM encoding and GF(2^8)/S-box helpers shared by the cipher cores.
package aes_pkg;
  localparam int Nb = 4;
  typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} fsm_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] mul9(input logic [7:0] a); return gfMul(a, 8'h09); endfunction
  function automatic logic [7:0] mulB(input logic [7:0] a); return gfMul(a, 8'h0b); endfunction
  function automatic logic [7:0] mulD(input logic [7:0] a); return gfMul(a, 8'h0d); endfunction
  function automatic logic [7:0] mulE(input logic [7:0] a); return gfMul(a, 8'h0e); endfunction
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gfMul(p, p);
      r = gfMul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gfInv(a);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return gfInv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction
  // byte index (row + Nb*col) that InvShiftRows moves into position i
  function automatic int invShiftSrc(input int i);
    return (i % Nb) + Nb * (((i / Nb) - (i % Nb)) & (Nb - 1));
  endfunction
  function automatic logic [31:0] invMixCol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mulE(a0) ^ mulB(a1) ^ mulD(a2) ^ mul9(a3),
            mul9(a0) ^ mulE(a1) ^ mulB(a2) ^ mulD(a3),
            mulD(a0) ^ mul9(a1) ^ mulE(a2) ^ mulB(a3),
            mulB(a0) ^ mulD(a1) ^ mul9(a2) ^ mulE(a3)};
  endfunction
endpackage

// File: rtl/inv_cipher_if.sv
// inv_cipher_if: start/busy/done block bus between the datapath (master) and the inverse cipher (slave).
interface inv_cipher_if #(parameter int Nk = 4);
  localparam int Nr = Nk + 6;
  logic enable;
  logic [0:127] cipherText;
  logic [0:128*(Nr+1)-1] keys;
  logic [0:127] decryptedText;
  logic busy;
  logic done;
  modport master (output enable, cipherText, keys, input decryptedText, busy, done);
  modport slave (input enable, cipherText, keys, output decryptedText, busy, done);
endinterface

// File: rtl/inv_cipher_round.sv
// inv_round: one combinational AES inverse round; InvMixColumns is skipped on the final round.
module inv_round
  import aes_pkg::*;
(
  input  logic [0:127] stateIn,
  input  logic [0:127] roundKey,
  input  logic         isFinal,
  output logic [0:127] stateOut
);
  logic [0:127] keyed;
  for (genvar i = 0; i < 16; i++) begin : gByte
    assign keyed[8*i +: 8] = invSbox(stateIn[8*invShiftSrc(i) +: 8]) ^ roundKey[8*i +: 8];
  end
  for (genvar c = 0; c < Nb; c++) begin : gCol
    assign stateOut[32*c +: 32] = isFinal ? keyed[32*c +: 32] : invMixCol(keyed[32*c +: 32]);
  end
endmodule

// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES inverse cipher, one round per clock.
// INV_CIPHER_KEY_LATCH_EN captures the key schedule at accept so the keys bus may change mid-block.
module inv_cipher
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input logic clks,
  input logic reset,
  inv_cipher_if.slave bus
);
  localparam int Nr = Nk + 6;
  fsm_t fsm, nextFsm;
  logic [3:0] round;
  logic [0:127] blockState, roundKey, nextState, decryptedText;
  logic [0:128*(Nr+1)-1] keySrc;
  logic accept, isFinal, busy, done;
`ifdef INV_CIPHER_KEY_LATCH_EN
  logic [0:128*(Nr+1)-1] keyLatch;
  always_ff @(posedge clks or posedge reset)
    if (reset) keyLatch <= '0;
    else if (accept) keyLatch <= bus.keys;
  assign keySrc = keyLatch;
`else
  assign keySrc = bus.keys;
`endif
  always_ff @(posedge clks or posedge reset)
    if (reset) fsm <= IDLE;
    else fsm <= nextFsm;
  always_comb
    nextFsm = fsm == IDLE ? (bus.enable ? ROUNDS : IDLE) :
              fsm == ROUNDS ? (round == 4'd1 ? FINAL : ROUNDS) : IDLE;
  always_comb begin
    accept = fsm == IDLE && bus.enable;
    isFinal = fsm == FINAL;
    roundKey = keySrc[128*round +: 128];
  end
  inv_round uRound (.stateIn(blockState), .roundKey(roundKey), .isFinal(isFinal), .stateOut(nextState));
  // the initial AddRoundKey uses the live bus: the latch only becomes valid after this edge
  always_ff @(posedge clks or posedge reset)
    if (reset) begin
      blockState <= '0;
      round <= '0;
      decryptedText <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= isFinal;
      if (accept) begin
        blockState <= bus.cipherText ^ bus.keys[128*Nr +: 128];
        round <= 4'(Nr - 1);
        busy <= 1'b1;
      end else if (fsm == ROUNDS) begin
        blockState <= nextState;
        round <= round - 4'd1;
      end else if (isFinal) begin
        decryptedText <= nextState;
        busy <= 1'b0;
        round <= '0;
      end
    end
  assign bus.decryptedText = decryptedText;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
